ren_conv_wb_master: RTL
=======================

Name: ren_conv_wb_master

Overview:
- Wishbone classic initiator that drives the multi-instance conv accelerator slave bus.
- Executes burst-like sequences of single-word transfers: writes image/kernel words from a streaming source, or reads result words into a streaming sink.
- Sits between the host-side sequencer and the accelerator's wbs_* port set.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width (sel width = DATA_WIDTH/8).
- LEN_WIDTH, 8, width of the command word count.
- TIMEOUT_CYCLES, 64, ack watchdog limit (used only with the optional feature).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_we  in  1  1 = write sequence, 0 = read sequence.
- cmd_addr  in  ADDR_WIDTH  byte address of first word; [31:24] selects instance (8'h30+i).
- cmd_len  in  LEN_WIDTH  number of words.
- wr_data  in  DATA_WIDTH  write stream data.
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  write word consumed.
- rd_data  out  DATA_WIDTH  read stream data.
- rd_valid  out  1  read stream valid.
- rd_ready  in  1  read stream accept.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle abort pulse (timeout feature only; otherwise tied 0).
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  DATA_WIDTH/8  byte select, all ones.
- wbm_adr_o  out  ADDR_WIDTH  address.
- wbm_dat_o  out  DATA_WIDTH  write data.
- wbm_ack_i  in  1  slave ack (OR of instance acks).
- wbm_dat_i  in  DATA_WIDTH  slave read data.

Behaviour:
- One clock; reset is synchronous and active-high (wb_clk_i, wb_rst_i).
- Reset values:
  - cyc, stb, we, busy, done, err, rd_valid, wr_ready = 0.
  - adr, dat_o, rd_data = 0.
  - State = IDLE; cmd_ready = 1 in the cycle after reset deasserts.
- All outputs are registered except cmd_ready (decoded from state) and wbm_sel_o (constant all ones).
- IDLE:
  - Handshake is cmd_valid & cmd_ready at edge T. Latch we, addr, and remaining count = cmd_len.
  - If cmd_len == 0: done = 1 at T+1, no bus activity, stay IDLE.
  - Otherwise go to ISSUE; busy = 1 from T+1.
- ISSUE:
  - Read: assert cyc/stb/adr.
  - Write: wait for wr_valid, then assert cyc/stb/we/adr/dat_o = wr_data. wr_ready pulses in the same cycle, so the word is consumed at assertion.
  - Go to WAIT.
- WAIT:
  - Hold cyc/stb/adr/dat_o stable until wbm_ack_i.
  - On ack edge: deassert cyc/stb next cycle (exactly one idle bus cycle between beats), addr += 4 with natural modulo-2^ADDR_WIDTH wrap, count -= 1.
  - Read: capture wbm_dat_i into rd_data, set rd_valid, go to RHOLD.
  - Write: go to ISSUE if count > 0, else FINISH.
- RHOLD:
  - rd_valid held with rd_data stable until rd_ready.
  - On accept: rd_valid clears; go to ISSUE if count > 0, else FINISH.
  - No new bus request while a read word is unaccepted.
- FINISH: done = 1 for one cycle, busy = 0, go to IDLE. cmd_ready is high in the next cycle.
- Ack while stb is low is ignored.
- wbm_dat_i is sampled only in WAIT with ack high.
- cmd_valid while busy has no effect.
- Reset mid-sequence: cyc/stb are low one cycle after the reset edge; remaining words are discarded and no done pulse is issued.

Optional Feature:
- Macro REN_WB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT and reloads on entry.
  - If TIMEOUT_CYCLES cycles pass with no ack: drop cyc/stb, pulse err for one cycle, clear busy, discard the remaining count, return to IDLE. No done pulse is issued.
- Undefined: no counter; WAIT waits indefinitely; err is tied to 0.

Decomposition:
- Shared package ren_conv_pkg holds:
  - State encoding (IDLE, ISSUE, WAIT, RHOLD, FINISH).
  - Instance base constant 8'h30 and the address stride of 4.
  - Instance-select field position [25:24].
- One natural sub-module: ren_wb_ack_watchdog (the timeout counter), instantiated only under REN_WB_TIMEOUT_EN.

Test Plan:
- Write sequence:
  - Stimulus: cmd_we=1, addr 32'h3000_0000, len 3; wr_data 11,22,33 always valid; slave acks 1 cycle after stb.
  - Response: three beats at adr 0x0,0x4,0x8 with dat_o 11,22,33; one idle bus cycle between beats; done one cycle after the last ack cycle.
- Read sequence:
  - Stimulus: cmd_we=0, addr 32'h3100_0010, len 2; slave returns AAAA_0001, AAAA_0002; rd_ready held low 5 cycles.
  - Response: rd_data stable at AAAA_0001 with rd_valid high; no second stb until accept; second beat at 0x3100_0014.
- Zero-length command:
  - Stimulus: len 0.
  - Response: done at T+1; cyc never asserted; busy stays 0.
- Stalled write source:
  - Stimulus: wr_valid low for 4 cycles in ISSUE.
  - Response: stb stays low throughout; beat issues in the cycle wr_valid rises.
- Reset mid-transfer:
  - Stimulus: assert wb_rst_i during WAIT of beat 2 of 4.
  - Response: cyc/stb low next cycle; no done; a new command is accepted afterwards from a fresh address.
- Timeout (REN_WB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: slave never acks.
  - Response: cyc drops after 8 WAIT cycles; err pulses once; no done; cmd_ready high.

Source files
------------

// File: rtl/ren_conv_pkg.sv
// Shared definitions for the conv accelerator Wishbone initiator:
// FSM state encoding, instance address map constants and the beat stride.
package ren_conv_pkg;

  // Sequencer states of the Wishbone initiator
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RHOLD  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Accelerator instance i lives at address byte [31:24] = INST_BASE + i
  localparam logic [7:0] INST_BASE = 8'h30;

  // Instance-select field inside the byte address
  localparam int INST_SEL_MSB = 25;
  localparam int INST_SEL_LSB = 24;

  // Byte distance between consecutive 32-bit words of a sequence
  localparam int ADDR_STRIDE = 4;

  // Instance index addressed by a byte address
  function automatic logic [1:0] inst_sel(input logic [31:0] byte_addr);
    return byte_addr[INST_SEL_MSB:INST_SEL_LSB];
  endfunction

endpackage

// File: rtl/ren_wb_ack_watchdog.sv
// Ack watchdog for the conv Wishbone initiator. Only built when the
// REN_WB_TIMEOUT_EN macro is defined; counts consecutive WAIT cycles and
// flags expiry in the TIMEOUT_CYCLES-th one.
`ifdef REN_WB_TIMEOUT_EN
module ren_wb_ack_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Expiry is decoded combinationally so the FSM can abort on the same edge
  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Counter restarts from zero whenever the FSM is outside WAIT
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!run_i) begin
      cnt_q <= '0;
    end else if (!expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule
`endif

// File: rtl/ren_conv_wb_master.sv
// Wishbone classic initiator for the multi-instance conv accelerator.
// Runs sequences of single-word transfers: writes words from a streaming
// source or reads words into a streaming sink, one idle bus cycle between
// beats. Optional ack watchdog: define REN_WB_TIMEOUT_EN.
module ren_conv_wb_master
  import ren_conv_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_ack_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i
);

  state_e                  state_q;
  logic                    we_seq_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic                    cyc_q;
  logic                    stb_q;
  logic                    we_o_q;
  logic [ADDR_WIDTH-1:0]   adr_o_q;
  logic [DATA_WIDTH-1:0]   dat_o_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    wr_ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [LEN_WIDTH-1:0]    cnt_d;
  logic                    timeout_s;

  // Next word address wraps naturally at 2^ADDR_WIDTH
  assign addr_d = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
  assign cnt_d  = cnt_q - LEN_WIDTH'(1);

`ifdef REN_WB_TIMEOUT_EN
  logic err_q;
  logic wd_expired_s;

  ren_wb_ack_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ack_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .run_i     (state_q == ST_WAIT),
    .expired_o (wd_expired_s)
  );

  // A late ack in the expiry cycle still wins over the abort
  assign timeout_s = wd_expired_s && !wbm_ack_i;
  assign err       = err_q;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign wbm_sel_o = '1;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_o_q;
  assign wbm_adr_o = adr_o_q;
  assign wbm_dat_o = dat_o_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Sequencer FSM with all bus and stream outputs registered
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      we_seq_q   <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_o_q     <= 1'b0;
      adr_o_q    <= '0;
      dat_o_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef REN_WB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      wr_ready_q <= 1'b0;
`ifdef REN_WB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            we_seq_q <= cmd_we;
            addr_q   <= cmd_addr;
            cnt_q    <= cmd_len;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (!we_seq_q) begin
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_o_q  <= 1'b0;
            adr_o_q <= addr_q;
            state_q <= ST_WAIT;
          end else if (wr_valid) begin
            // The source word is consumed as the beat is launched
            cyc_q      <= 1'b1;
            stb_q      <= 1'b1;
            we_o_q     <= 1'b1;
            adr_o_q    <= addr_q;
            dat_o_q    <= wr_data;
            wr_ready_q <= 1'b1;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wbm_ack_i) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            we_o_q <= 1'b0;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            if (!we_seq_q) begin
              rd_data_q  <= wbm_dat_i;
              rd_valid_q <= 1'b1;
              state_q    <= ST_RHOLD;
            end else if (cnt_d != '0) begin
              state_q <= ST_ISSUE;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FINISH;
            end
          end else if (timeout_s) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_o_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`ifdef REN_WB_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
            state_q <= ST_IDLE;
          end
        end
        ST_RHOLD: begin
          // No further bus request until the sink takes the word
          if (rd_ready) begin
            rd_valid_q <= 1'b0;
            if (cnt_q != '0) begin
              state_q <= ST_ISSUE;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
